// File: rtl/seq_frame_tx.sv
// Serial 1011-sync frame transmitter: sync, payload MSB-first, then a zero guard gap on x.
// Latency: first sync bit one cycle after acceptance; frame period SYNC_W+DATA_W+GAP_LEN+1.
// Backpressure: ready only in IDLE; load while busy is dropped, never queued.
module seq_frame_tx #(
  parameter int                DATA_W  = 8,
  parameter int                SYNC_W  = 4,
  parameter logic [SYNC_W-1:0] SYNC    = 4'b1011,
  parameter int                GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              x,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAXL = (SYNC_W > DATA_W) ? ((SYNC_W > GAP_LEN) ? SYNC_W : GAP_LEN)
                                          : ((DATA_W > GAP_LEN) ? DATA_W : GAP_LEN);
  localparam int CW = $clog2(MAXL + 1);
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_W - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_DATA, ST_GAP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [DATA_W-1:0] sh, sh_n;
  logic [SYNC_W-1:0] sync_sr, sync_n;
  logic              x_n, done_n, busy_n;

  assign ready = (state == ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      sh         <= '0;
      sync_sr    <= '0;
      x          <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sh         <= sh_n;
      sync_sr    <= sync_n;
      x          <= x_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

  // x is the registered next bit, so each phase loads its first bit on the entering edge
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    sh_n    = sh;
    sync_n  = sync_sr;
    x_n     = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (load) begin
          state_n = ST_SYNC;
          sh_n    = data;
          x_n     = SYNC[SYNC_W-1];
          sync_n  = SYNC << 1;
        end
      end
      ST_SYNC: begin
        if (cnt == SYNC_LAST) begin
          state_n = ST_DATA;
          cnt_n   = '0;
          x_n     = sh[DATA_W-1];
          sh_n    = sh << 1;
        end else begin
          x_n    = sync_sr[SYNC_W-1];
          sync_n = sync_sr << 1;
        end
      end
      ST_DATA: begin
        if (cnt == DATA_LAST) begin
          state_n = ST_GAP;
          cnt_n   = '0;
        end else begin
          x_n  = sh[DATA_W-1];
          sh_n = sh << 1;
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    busy_n = (state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Bench for seq_frame_tx: frame-position model for a default and a DATA_W=1/GAP_LEN=1 instance.
module tb_seq_frame_tx;
  localparam int SW  = 4;
  localparam int DW  = 8;
  localparam int GL  = 2;
  localparam int N   = SW + DW + GL;
  localparam int DW1 = 1;
  localparam int GL1 = 1;
  localparam int N1  = SW + DW1 + GL1;
  localparam logic [3:0] SYNCV = 4'b1011;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load0 = 1'b0;
  logic [7:0] data0 = 8'h00;
  logic       ready0, x0, busy0, fd0;
  logic       load1 = 1'b0;
  logic [0:0] data1 = 1'b0;
  logic       ready1, x1, busy1, fd1;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  seq_frame_tx u0 (
    .clk(clk), .reset(reset), .load(load0), .data(data0),
    .ready(ready0), .x(x0), .busy(busy0), .frame_done(fd0)
  );

  seq_frame_tx #(.DATA_W(DW1), .GAP_LEN(GL1)) u1 (
    .clk(clk), .reset(reset), .load(load1), .data(data1),
    .ready(ready1), .x(x1), .busy(busy1), .frame_done(fd1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // t = cycles since the accepting edge (0 = idle); expected bit is pure frame arithmetic
  function automatic logic exp_x(input int t, input int dw, input logic [7:0] cap);
    int i;
    if (t == 0) return 1'b0;
    i = t - 1;
    if (i < SW) return SYNCV[SW-1-i];
    if (i < SW + dw) return cap[dw-1-(i-SW)];
    return 1'b0;
  endfunction

  int t0 = 0, t1 = 0;
  bit d0 = 0, d1 = 0;
  logic [7:0] cap0 = 8'h00, cap1 = 8'h00;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      t0 = 0; d0 = 0; t1 = 0; d1 = 0;
    end else begin
      if (t0 == 0) begin
        d0 = 0;
        if (load0) begin t0 = 1; cap0 = data0; end
      end else if (t0 == N) begin
        t0 = 0; d0 = 1;
      end else begin
        t0++; d0 = 0;
      end
      if (t1 == 0) begin
        d1 = 0;
        if (load1) begin t1 = 1; cap1 = {7'b0, data1}; end
      end else if (t1 == N1) begin
        t1 = 0; d1 = 1;
      end else begin
        t1++; d1 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_x0",    x0,     exp_x(t0, DW, cap0));
      chk("m_rdy0",  ready0, t0 == 0);
      chk("m_busy0", busy0,  t0 != 0);
      chk("m_fd0",   fd0,    d0);
      chk("m_x1",    x1,     exp_x(t1, DW1, cap1));
      chk("m_rdy1",  ready1, t1 == 0);
      chk("m_busy1", busy1,  t1 != 0);
      chk("m_fd1",   fd1,    d1);
    end
  end

  // Behavioural 1011 detector on the serial line, one bit per cycle, overlapping
  logic [3:0] hist = 4'b0;
  int zcnt = 0;
  always @(negedge clk) begin
    hist = {hist[2:0], x0};
    if (hist == 4'b1011) zcnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send0(input logic [7:0] d);
    data0 = d; load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
  endtask

  initial begin
    logic [13:0] pat;
    logic [12:0] pat1;
    logic [7:0]  got;
    int zs;

    chk_on = 1'b1;
    cyc(2);
    chk("rst_x", x0, 0);
    chk("rst_ready", ready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", fd0, 0);
    reset = 1'b1;
    cyc(2);

    // single A5 frame
    pat = 14'b10111010010100;
    send0(8'hA5);
    for (int c = 1; c <= 15; c++) begin
      if (c <= 14) begin
        chk("a5_x", x0, pat[14-c]);
        chk("a5_ready", ready0, 0);
        chk("a5_nodone", fd0, 0);
      end else begin
        chk("a5_done", fd0, 1);
        chk("a5_ready_back", ready0, 1);
      end
      @(negedge clk);
    end
    chk("a5_done_once", fd0, 0);
    cyc(2);

    // load while busy is dropped
    send0(8'hFF);
    for (int c = 1; c <= 22; c++) begin
      if (c == 5) begin load0 = 1'b1; data0 = 8'h00; end
      if (c == 6) load0 = 1'b0;
      if (c >= 6 && c <= 12) chk("ff_payload", x0, 1);
      if (c >= 16) chk("ff_no_second", ready0, 1);
      @(negedge clk);
    end

    // back-to-back with load held high
    data0 = 8'h3C; load0 = 1'b1;
    @(negedge clk);
    data0 = 8'hC3;
    got = 8'h00;
    for (int c = 1; c <= 16; c++) begin
      if (c >= 5 && c <= 12) got = {got[6:0], x0};
      if (c == 15) begin chk("b2b_gap_ready", ready0, 1); chk("b2b_gap_done", fd0, 1); end
      if (c == 16) begin
        load0 = 1'b0;
        chk("b2b_sync2_x", x0, 1);
        chk("b2b_sync2_busy", ready0, 0);
      end
      @(negedge clk);
    end
    chk("b2b_pay1", got, 8'h3C);
    got = 8'h00;
    for (int c = 17; c <= 30; c++) begin
      if (c >= 20 && c <= 27) got = {got[6:0], x0};
      @(negedge clk);
    end
    chk("b2b_pay2", got, 8'hC3);
    cyc(3);

    // reset mid-frame
    send0(8'hFF);
    cyc(6);
    chk("mid_x_before", x0, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_x_async", x0, 0);
    chk("mid_ready_async", ready0, 1);
    chk("mid_busy_async", busy0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk("mid_no_done", fd0, 0);
      @(negedge clk);
    end
    send0(8'h81);
    got = 8'h00;
    for (int c = 1; c <= 16; c++) begin
      if (c >= 5 && c <= 12) got = {got[6:0], x0};
      @(negedge clk);
    end
    chk("post_rst_pay", got, 8'h81);

    // loopback detector counts
    zs = zcnt;
    send0(8'h0B);
    cyc(18);
    chk("det_0b", zcnt - zs, 2);
    zs = zcnt;
    send0(8'h00);
    cyc(18);
    chk("det_00", zcnt - zs, 1);

    // narrow instance: period 7, frame 1,0,1,1,d,0
    pat1 = 13'b1011100101100;
    data1 = 1'b1; load1 = 1'b1;
    @(negedge clk);
    data1 = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      if (c == 8) load1 = 1'b0;
      if (c == 7) begin
        chk("n_done", fd1, 1);
        chk("n_ready", ready1, 1);
      end
      chk("n_x", x1, pat1[13-c]);
      @(negedge clk);
    end
    cyc(4);

    // random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      load0 = ($urandom_range(0, 2) == 0);
      data0 = 8'($urandom);
      load1 = ($urandom_range(0, 3) == 0);
      data1 = 1'($urandom);
      @(negedge clk);
    end
    load0 = 1'b0; load1 = 1'b0;
    cyc(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_frame_tx.md
# seq_frame_tx

Serial frame transmitter: the transmit end of the 1011 sequence-detection link. It accepts a parallel payload through a valid/ready handshake and drives a single-bit stream on `x`. Each frame is the 4-bit sync pattern 1011, then the payload MSB-first, then a guard gap of zeros. Its `x` output feeds the Moore 1011 detector's `x` input directly, so bench stimulus can be generated from data instead of hand-timed delays.

## Interface
- `DATA_W`, default 8: payload width in bits (≥1).
- `SYNC`, default 4'b1011: sync pattern, sent MSB-first.
- `SYNC_W`, default 4: sync pattern width.
- `GAP_LEN`, default 2: zero bits after the payload (≥1).
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset (0 = reset asserted).
- `load`  in  1: payload valid; sampled on a rising edge.
- `data`  in  DATA_W: payload; captured on the accepting edge only.
- `ready`  out  1: high when idle and able to accept.
- `x`  out  1: registered serial bit stream.
- `busy`  out  1: high while a frame is being sent.
- `frame_done`  out  1: one-cycle pulse when a frame completes.

## Operation
- FSM states are IDLE, SYNC, DATA and GAP. `ready = (state == IDLE)`; `busy = !ready`.
- IDLE:
  - `x = 0`.
  - On an edge with `load && ready`, `data` is copied to the shift register, the bit counter is cleared, and the state goes to SYNC.
  - `load` while not ready is ignored: no capture and no queueing.
- SYNC: `x` steps through `SYNC[SYNC_W-1]` down to `SYNC[0]`, one bit per cycle. After SYNC_W bits the state goes to DATA.
- DATA: `x` steps through `data[DATA_W-1]` down to `data[0]`, taken from the captured copy. After DATA_W bits the state goes to GAP.
- GAP: `x = 0` for GAP_LEN cycles, then the state goes to IDLE and `frame_done` pulses.
- Payload changes after acceptance have no effect on the frame in flight.
- There is one shared bit counter, sized `$clog2(max(SYNC_W, DATA_W, GAP_LEN)+1)` and cleared on every state change. There is no wrap-around inside a phase.
- The gap guarantees at least one 0 between frames, so the detector never sees a 1011 that straddles two frames.

## Timing
- Reset (reset = 0, asynchronous): state IDLE, `x = 0`, `busy = 0`, `ready = 1`, `frame_done = 0`, counter and shift register 0.
- Reset mid-frame aborts the frame immediately:
  - `x` drops to 0 asynchronously.
  - No `frame_done` pulse is produced.
  - The first edge after release behaves as IDLE.
- Let E0 be the accepting edge.
  - In the cycle after edge E0+i:
    - i = 0 … SYNC_W-1: `x` = sync bit.
    - i = SYNC_W … SYNC_W+DATA_W-1: `x` = payload bit.
    - next GAP_LEN cycles: `x = 0`.
  - Edge E0+N, where N = SYNC_W+DATA_W+GAP_LEN (14 with defaults), returns the FSM to IDLE. During the cycle that follows, `ready = 1` and `frame_done = 1` for exactly one cycle.
- Back-to-back: `load` held high is accepted at E0+N+1, so the frame period is N+1 = 15 cycles. The IDLE cycle adds one more 0 between frames.
- Latency: the first sync bit appears one cycle after acceptance.
- `frame_done` and a new acceptance can share an edge: a `load` sampled at the edge that ends the `frame_done` cycle is accepted, and `frame_done` still deasserts.
- `x`, `busy` and `frame_done` are registered; `ready` is decoded from the state register.

## Test plan
- Single frame, `data = 8'hA5`, one-cycle `load`:
  - `x` = 1,0,1,1, 1,0,1,0,0,1,0,1, 0,0 on cycles 1–14.
  - `frame_done` high on cycle 15 only.
  - `ready` low on cycles 1–14.
- Load while busy: accept 8'hFF, then pulse `load` with 8'h00 on cycle 5 → the frame is still the FF frame and no second frame starts.
- Back-to-back: `load` held high with 8'h3C then 8'hC3 → second sync starts at cycle 16 (period 15), and the payloads are exact.
- Reset mid-frame: assert `reset = 0` during cycle 7 → `x = 0` and `ready = 1` immediately, no `frame_done`; after release, a new 8'h81 frame is sent correctly.
- Loopback into the 1011 detector:
  - `data = 8'h0B` → exactly two `z` pulses: one after the sync, one after the payload.
  - `data = 8'h00` → exactly one `z` pulse.
- Parameter sweep: `DATA_W = 1` and `GAP_LEN = 1` → frame `x` = 1,0,1,1,d,0 and period 7.
